// File: rtl/pio_2401_dr.sv
// rtl/pio_2401_dr.sv - Avalon-MM input PIO for nRF2401 DR pins with edge capture and irq
// Optional per-bit glitch filter compiled in with PIO_2401_DR_FILTER_EN.
`timescale 1ns/1ps
module pio_2401_dr #(
  parameter int WIDTH         = 1,
  parameter int EDGE_TYPE     = 0,
  parameter int FILTER_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] readdata,
  output logic             irq
);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] fprev_q;
  logic [WIDTH-1:0] edge_w;
  logic [WIDTH-1:0] clr_w;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             wr_en, rd_en;

  assign wr_en = chipselect & ~write_n;
  assign rd_en = chipselect & ~read_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= in_port;
      s2_q <= s1_q;
    end
  end

`ifdef PIO_2401_DR_FILTER_EN
  localparam logic [7:0] FILT_LAST = 8'(FILTER_CYCLES - 2);

  logic [7:0]       cnt_q [WIDTH];
  logic [7:0]       cnt_d [WIDTH];
  logic [WIDTH-1:0] filt_q, filt_d;

  // f only follows s2 after it has disagreed for FILTER_CYCLES-1 consecutive clocks
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == filt_q[i]) begin
        cnt_d[i] = 8'd0;
      end else if (cnt_q[i] == FILT_LAST) begin
        cnt_d[i]  = 8'd0;
        filt_d[i] = s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= 8'd0;
    end else begin
      filt_q <= filt_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign f = filt_q;
`else
  assign f = s2_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fprev_q <= '0;
    else          fprev_q <= f;
  end

  always_comb begin
    case (EDGE_TYPE)
      1:       edge_w = ~f & fprev_q;
      2:       edge_w = f ^ fprev_q;
      default: edge_w = f & ~fprev_q;
    endcase
  end

  assign clr_w = (wr_en && address == 2'd3) ? writedata : '0;

  // New edges OR in after the clear so a coincident edge is never lost
  always_comb begin
    cap_d  = (cap_q & ~clr_w) | edge_w;
    mask_d = mask_q;
    if (wr_en && address == 2'd2) mask_d = writedata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      case (address)
        2'd0:    rdata_d = f;
        2'd2:    rdata_d = mask_q;
        2'd3:    rdata_d = cap_q;
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_q   <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
    end else begin
      cap_q   <= cap_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_pio_2401_dr.sv
// tb/tb_pio_2401_dr.sv - directed self-checking bench for pio_2401_dr
// Three instances: rising WIDTH=1, falling WIDTH=1, any-edge WIDTH=2.
`timescale 1ns/1ps
module tb_pio_2401_dr;

`ifdef PIO_2401_DR_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] address = 2'd0;
  logic [2:0] cs = 3'd0;
  logic       read_n = 1'b1;
  logic       write_n = 1'b1;
  logic [1:0] wdata = 2'd0;
  logic       in0 = 1'b0;
  logic       in1 = 1'b0;
  logic [1:0] in2 = 2'd0;
  logic       rd0, rd1;
  logic [1:0] rd2;
  logic       irq0, irq1, irq2;
  logic [1:0] v;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  pio_2401_dr #(.WIDTH(1), .EDGE_TYPE(0), .FILTER_CYCLES(4)) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[0]),
    .read_n(read_n), .write_n(write_n), .writedata(wdata[0:0]),
    .in_port(in0), .readdata(rd0), .irq(irq0));

  pio_2401_dr #(.WIDTH(1), .EDGE_TYPE(1), .FILTER_CYCLES(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[1]),
    .read_n(read_n), .write_n(write_n), .writedata(wdata[0:0]),
    .in_port(in1), .readdata(rd1), .irq(irq1));

  pio_2401_dr #(.WIDTH(2), .EDGE_TYPE(2), .FILTER_CYCLES(4)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[2]),
    .read_n(read_n), .write_n(write_n), .writedata(wdata),
    .in_port(in2), .readdata(rd2), .irq(irq2));

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int d, input logic [1:0] a, input logic [1:0] val);
    @(posedge clk); #1;
    cs = 3'(1 << d); address = a; wdata = val; write_n = 1'b0;
    @(posedge clk); #1;
    cs = 3'd0; write_n = 1'b1;
  endtask

  task automatic rchk(input int d, input logic [1:0] a, input logic [1:0] exp, input string tag);
    logic [1:0] got;
    @(posedge clk); #1;
    cs = 3'(1 << d); address = a; read_n = 1'b0;
    @(posedge clk); #1;
    cs = 3'd0; read_n = 1'b1;
    @(negedge clk);
    got = (d == 0) ? {1'b0, rd0} : (d == 1) ? {1'b0, rd1} : rd2;
    chk(tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    chk("rst_irq0", {1'b0, irq0}, 2'd0);
    chk("rst_irq2", {1'b0, irq2}, 2'd0);
    for (int a = 0; a < 4; a++) rchk(0, 2'(a), 2'd0, "rst_read_dut0");
    for (int a = 0; a < 4; a++) rchk(2, 2'(a), 2'd0, "rst_read_dut2");

    // rising edge, latency to irq
    wr(0, 2'd2, 2'd1);
    rchk(0, 2'd2, 2'd1, "mask_rw");
    @(posedge clk); #1; in0 = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk); chk("rise_irq_early", {1'b0, irq0}, 2'd0);
    @(posedge clk);
    @(negedge clk); chk("rise_irq_on_time", {1'b0, irq0}, 2'd1);
    rchk(0, 2'd0, 2'd1, "rise_data");
    rchk(0, 2'd3, 2'd1, "rise_cap");
    wr(0, 2'd3, 2'd1);
    @(negedge clk); chk("w1c_irq", {1'b0, irq0}, 2'd0);
    rchk(0, 2'd3, 2'd0, "w1c_cap");

    // falling edge, masked then unmasked
    in1 = 1'b1; tick(LAT + 2);
    rchk(1, 2'd3, 2'd0, "fall_ignores_rise");
    in1 = 1'b0; tick(LAT + 2);
    rchk(1, 2'd3, 2'd1, "fall_cap");
    chk("fall_masked_irq", {1'b0, irq1}, 2'd0);
    wr(1, 2'd2, 2'd1);
    @(negedge clk); chk("fall_unmask_irq", {1'b0, irq1}, 2'd1);
    wr(1, 2'd3, 2'd1);
    @(negedge clk); chk("fall_clear_irq", {1'b0, irq1}, 2'd0);

    // clear write lands on the same edge that sets the capture bit
    in1 = 1'b1; tick(LAT + 2);
    @(posedge clk); #1; in1 = 1'b0;
    repeat (LAT - 2) @(posedge clk);
    wr(1, 2'd3, 2'd1);
    @(negedge clk); chk("simul_irq", {1'b0, irq1}, 2'd1);
    rchk(1, 2'd3, 2'd1, "simul_cap");

    // two-bit any-edge, per-bit clear and masking
    wr(2, 2'd2, 2'b11);
    in2 = 2'b10; tick(LAT + 2);
    rchk(2, 2'd3, 2'b10, "any_bit1_cap");
    chk("any_irq", {1'b0, irq2}, 2'd1);
    wr(2, 2'd3, 2'b01);
    rchk(2, 2'd3, 2'b10, "w1c_other_bit");
    wr(2, 2'd2, 2'b01);
    @(negedge clk); chk("mask_drop_irq", {1'b0, irq2}, 2'd0);
    rchk(2, 2'd3, 2'b10, "cap_retained");
    wr(2, 2'd2, 2'b11);
    @(negedge clk); chk("mask_reassert_irq", {1'b0, irq2}, 2'd1);
    rchk(2, 2'd1, 2'b00, "reserved_read");
    wr(2, 2'd3, 2'b10);
    rchk(2, 2'd3, 2'b00, "w1c_bit1");
    chk("any_irq_clear", {1'b0, irq2}, 2'd0);
    in2 = 2'b01; tick(LAT + 2);
    rchk(2, 2'd3, 2'b11, "any_both_edges");
    rchk(2, 2'd0, 2'b01, "any_data");
    wr(2, 2'd0, 2'b10);
    rchk(2, 2'd0, 2'b01, "data_write_ignored");
    wr(2, 2'd3, 2'b11);
    rchk(2, 2'd3, 2'b00, "w1c_both");

`ifdef PIO_2401_DR_FILTER_EN
    in0 = 1'b0; tick(LAT + 2);
    // 2-clock pulse must be swallowed
    @(posedge clk); #1; in0 = 1'b1;
    repeat (2) @(posedge clk);
    #1; in0 = 1'b0;
    tick(10);
    rchk(0, 2'd0, 2'd0, "filt_pulse_data");
    rchk(0, 2'd3, 2'd0, "filt_pulse_cap");
    chk("filt_pulse_irq", {1'b0, irq0}, 2'd0);
    // 10-clock level passes with 6-clock latency
    @(posedge clk); #1; in0 = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk); chk("filt_level_early", {1'b0, irq0}, 2'd0);
    @(posedge clk);
    @(negedge clk); chk("filt_level_irq", {1'b0, irq0}, 2'd1);
    rchk(0, 2'd0, 2'd1, "filt_level_data");
    in0 = 1'b0; tick(LAT + 2);
    wr(0, 2'd3, 2'd1);
    @(negedge clk); chk("filt_clear_irq", {1'b0, irq0}, 2'd0);
    // reset mid-count
    @(posedge clk); #1; in0 = 1'b1;
    repeat (4) @(posedge clk);
    #1; reset_n = 1'b0; in0 = 1'b0;
    tick(2);
    @(negedge clk); reset_n = 1'b1;
    tick(10);
    rchk(0, 2'd3, 2'd0, "rstmid_cap");
    rchk(0, 2'd2, 2'd0, "rstmid_mask");
    rchk(0, 2'd0, 2'd0, "rstmid_data");
    chk("rstmid_irq", {1'b0, irq0}, 2'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
